// File: rtl/core_mem_s_if.sv
`default_nettype none
// ============================================================================
//  Module      : core_mem_s_if
//  Description : Request/acknowledge bus between the memory-access stage and
//                the L1 data cache.
//  Ports       : master - the pipeline stage (issues req/we/addr/wdata/be,
//                         receives ack/rdata)
//                slave  - the L1D (receives the request, returns ack/rdata)
//  Revision    : 1.0 - initial release
// ============================================================================
interface core_mem_s_if;
    logic        mem_l1d_req_out;
    logic        mem_l1d_we_out;
    logic [31:0] mem_l1d_addr_out;
    logic [31:0] mem_l1d_wdata_out;
    logic [3:0]  mem_l1d_be_out;
    logic        mem_l1d_ack_in;
    logic [31:0] mem_l1d_rdata_in;

    modport master (
        output mem_l1d_req_out,
        output mem_l1d_we_out,
        output mem_l1d_addr_out,
        output mem_l1d_wdata_out,
        output mem_l1d_be_out,
        input  mem_l1d_ack_in,
        input  mem_l1d_rdata_in
    );

    modport slave (
        input  mem_l1d_req_out,
        input  mem_l1d_we_out,
        input  mem_l1d_addr_out,
        input  mem_l1d_wdata_out,
        input  mem_l1d_be_out,
        output mem_l1d_ack_in,
        output mem_l1d_rdata_in
    );
endinterface
`default_nettype wire

// File: rtl/core_mem_s.sv
`default_nettype none
// ============================================================================
//  Module      : core_mem_s
//  Description : Memory-access pipeline stage. Converts load/store operations
//                into word-aligned L1D requests with byte enables, stalls the
//                upstream stages until the cache acknowledges, right-aligns
//                load data and registers the result into MEM/WB.
//  Ports       : clk, rst_n (async, active-low)
//                mem_*_in   - EX/MEM pipeline register fields
//                l1d        - L1D request bus (master side)
//                mem_stall_out, mem_misalign_out - pipeline control
//                wb_*_out   - MEM/WB pipeline register
//  Revision    : 1.0 - initial release
// ============================================================================
module core_mem_s (
    input  wire         clk,
    input  wire         rst_n,
    input  wire         mem_valid_in,
    input  wire         mem_load_in,
    input  wire         mem_store_in,
    input  wire  [1:0]  mem_size_in,
    input  wire  [31:0] mem_alu_result_in,
    input  wire  [31:0] mem_store_data_in,
    input  wire  [31:0] mem_pc_4_in,
    input  wire  [31:0] mem_sx_imm_in,
    input  wire  [2:0]  mem_sx_op_in,
    input  wire         mem_mux_in,
    input  wire         mem_we_reg_file_in,
    input  wire  [4:0]  mem_rd_in,
    core_mem_s_if.master l1d,
    output logic        mem_stall_out,
    output logic        mem_misalign_out,
    output logic [31:0] wb_alu_result_out,
    output logic [31:0] wb_mem_data_out,
    output logic [31:0] wb_pc_4_out,
    output logic [31:0] wb_sx_imm_out,
    output logic [2:0]  wb_sx_op_out,
    output logic        wb_mux_out,
    output logic        wb_we_reg_file_out,
    output logic [4:0]  wb_rd_out,
    output logic        wb_valid_out
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]  state_q, state_d;

    logic [1:0]  w_off;
    logic        w_is_mem;
    logic        w_misaligned;
    logic        w_acc;
    logic        w_req;
    logic        w_stall;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;
    logic [31:0] w_wb_mem_data;

    logic [31:0] alu_q, mem_data_q, pc_4_q, sx_imm_q;
    logic [2:0]  sx_op_q;
    logic        mux_q, we_q, valid_q, misalign_q;
    logic [4:0]  rd_q;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    assign w_off    = mem_alu_result_in[1:0];
    assign w_is_mem = mem_valid_in & (mem_load_in | mem_store_in);

    // Size 11 is treated as a word, hence the test on size[1] only.
    assign w_misaligned = w_is_mem &
                          (((mem_size_in == 2'b01) & w_off[0]) |
                           (mem_size_in[1] & (w_off != 2'b00)));
    assign w_acc        = w_is_mem & ~w_misaligned;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = mem_store_data_in;
        case (mem_size_in)
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{mem_store_data_in[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << w_off;
                w_wdata = {2{mem_store_data_in[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = mem_store_data_in;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_acc & ~l1d.mem_l1d_ack_in) state_d = S_WAIT;
            S_WAIT:  if (l1d.mem_l1d_ack_in)          state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request FSM: outputs. rst_n gates the request so an access in flight
    // is withdrawn the moment reset asserts, not at the next edge.
    always_comb begin
        w_req = 1'b0;
        case (state_q)
            S_IDLE:  w_req = w_acc;
            S_WAIT:  w_req = 1'b1;
            default: w_req = 1'b0;
        endcase
        w_req = w_req & rst_n;
    end

    assign w_stall = w_req & ~l1d.mem_l1d_ack_in;

    assign l1d.mem_l1d_req_out   = w_req;
    assign l1d.mem_l1d_we_out    = w_req & mem_store_in;
    assign l1d.mem_l1d_addr_out  = {mem_alu_result_in[31:2], 2'b00};
    assign l1d.mem_l1d_wdata_out = w_wdata;
    assign l1d.mem_l1d_be_out    = w_be;
    assign mem_stall_out         = w_stall;

    // ------------------------------------------------------------------
    // Load data alignment. A load that reaches the capture point unstalled
    // always has its ack in this cycle, so rdata is valid here.
    // ------------------------------------------------------------------
    assign w_load_data   = l1d.mem_l1d_rdata_in >> {w_off, 3'b000};
    assign w_wb_mem_data = (w_acc & mem_load_in) ? w_load_data : 32'd0;

    // ------------------------------------------------------------------
    // MEM/WB pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_q      <= 32'd0;
            mem_data_q <= 32'd0;
            pc_4_q     <= 32'd0;
            sx_imm_q   <= 32'd0;
            sx_op_q    <= 3'd0;
            mux_q      <= 1'b0;
            we_q       <= 1'b0;
            rd_q       <= 5'd0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= w_misaligned;
            if (!w_stall) begin
                alu_q      <= mem_alu_result_in;
                mem_data_q <= w_wb_mem_data;
                pc_4_q     <= mem_pc_4_in;
                sx_imm_q   <= mem_sx_imm_in;
                sx_op_q    <= mem_sx_op_in;
                mux_q      <= mem_mux_in;
                we_q       <= mem_we_reg_file_in & mem_valid_in & ~w_misaligned;
                rd_q       <= mem_rd_in;
                valid_q    <= mem_valid_in;
            end else begin
                // Bubble: other fields hold their last value.
                we_q    <= 1'b0;
                valid_q <= 1'b0;
            end
        end
    end

    assign wb_alu_result_out  = alu_q;
    assign wb_mem_data_out    = mem_data_q;
    assign wb_pc_4_out        = pc_4_q;
    assign wb_sx_imm_out      = sx_imm_q;
    assign wb_sx_op_out       = sx_op_q;
    assign wb_mux_out         = mux_q;
    assign wb_we_reg_file_out = we_q;
    assign wb_rd_out          = rd_q;
    assign wb_valid_out       = valid_q;
    assign mem_misalign_out   = misalign_q;

endmodule
`default_nettype wire

// File: doc/core_mem_s.md
# core_mem_s

Memory-access stage of the core pipeline, between execute and write-back. It turns load/store operations into word-aligned L1 data-cache (L1D) requests with byte enables, and stalls the pipeline until the cache acknowledges. It right-aligns load data and registers the result into the write-back pipeline register. Write-back applies sign/zero extension to the captured value.

## Interface
Parameters: none.

Ports (all `_in` ports are driven by the EX/MEM pipeline register):
- `clk` in 1: core clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mem_valid_in` in 1: an instruction is present in the stage.
- `mem_load_in`, `mem_store_in` in 1 each: operation is a load or a store; never both high.
- `mem_size_in` in 2: access size; 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- `mem_alu_result_in` in 32: effective address, or the ALU result for non-memory ops.
- `mem_store_data_in` in 32: store data, right-aligned.
- `mem_pc_4_in`, `mem_sx_imm_in` in 32 each; `mem_sx_op_in` in 3; `mem_mux_in` in 1; `mem_we_reg_file_in` in 1; `mem_rd_in` in 5: passed through to write-back.
- `mem_l1d_req_out` out 1: L1D request.
- `mem_l1d_we_out` out 1: request is a write.
- `mem_l1d_addr_out` out 32: word address; bits [1:0] are always 0.
- `mem_l1d_wdata_out` out 32: lane-replicated write data.
- `mem_l1d_be_out` out 4: byte enables.
- `mem_l1d_ack_in` in 1: access complete; valid only while a request is high.
- `mem_l1d_rdata_in` in 32: read data, valid together with the ack.
- `mem_stall_out` out 1: freeze the upstream stages.
- `mem_misalign_out` out 1: registered one-cycle pulse on a misaligned access.
- `wb_alu_result_out`, `wb_mem_data_out`, `wb_pc_4_out`, `wb_sx_imm_out` out 32 each; `wb_sx_op_out` out 3; `wb_mux_out` out 1; `wb_we_reg_file_out` out 1; `wb_rd_out` out 5; `wb_valid_out` out 1: MEM/WB pipeline register outputs.

## Operation
Access decode:
- `acc = mem_valid_in & (mem_load_in | mem_store_in) & ~misaligned`.
- `off = mem_alu_result_in[1:0]`.
- Misaligned: a half-word access with `off[0]=1`, or a word access with `off != 0`. Byte accesses are never misaligned.

Byte enables and write data:
- Byte: `be = 4'b0001 << off`; `wdata = {4{d[7:0]}}`.
- Half: `be = 4'b0011 << off`; `wdata = {2{d[15:0]}}`.
- Word: `be = 4'b1111`; `wdata = d`.

Address: `mem_l1d_addr_out = {addr[31:2], 2'b00}`.

FSM, 2 states:
- IDLE: `req = acc`. If `acc & ~ack`, go to WAIT. If `acc & ack`, the access completes in this cycle and the FSM stays in IDLE.
- WAIT: `req = 1`, with address, we, be and wdata held from the live inputs; these stay stable because upstream is frozen. On `ack`, go to IDLE.

Stall and completion:
- `mem_stall_out = mem_l1d_req_out & ~mem_l1d_ack_in`.
- A load's captured data is `wb_mem_data_out = mem_l1d_rdata_in >> (8*off)`, so the addressed byte/half sits in the low bits.
- A non-memory instruction completes in a single cycle without a request. Its `wb_mem_data_out` is captured as 0.

Misaligned access:
- No request is issued and there is no stall.
- The instruction passes to write-back with `wb_we_reg_file_out = 0`.
- `mem_misalign_out` = 1 in the following cycle.

MEM/WB register:
- When `~mem_stall_out`, capture all pass-through fields. `wb_valid_out = mem_valid_in`, and `wb_we_reg_file_out = mem_we_reg_file_in & mem_valid_in & ~misaligned`.
- When `mem_stall_out`, load a bubble: `wb_valid_out = 0`, `wb_we_reg_file_out = 0`, other fields hold.

Boundary rules:
- `ack` while `req = 0` is ignored.
- A back-to-back access in the cycle after completion is issued from IDLE with no idle cycle.
- Reset mid-access drops `req` immediately (asynchronous). The L1D must discard the outstanding request.

## Timing
- Reset values: FSM = IDLE; all `wb_*` outputs = 0; `mem_misalign_out` = 0. `mem_l1d_req_out`, `mem_l1d_we_out` and `mem_stall_out` = 0 while `rst_n` = 0.
- L1D outputs and `mem_stall_out` are combinational from the inputs and the FSM state.
- Load with ack in request cycle N: no stall; `wb_*` valid at N+1.
- Load with ack at N+k: stall high for cycles N..N+k-1; bubbles in WB at N+1..N+k; result in WB at N+k+1.

## Test plan
- Word load at 0x100, ack in the same cycle with rdata 0xDEADBEEF: req=1, be=1111, addr=0x100, stall=0; next cycle wb_mem_data_out=0xDEADBEEF, wb_valid_out=1.
- Byte load at 0x203, ack delayed 3 cycles, rdata 0x80XXXXXX: stall high 3 cycles; WB shows bubbles for 3 cycles, then wb_mem_data_out=0x00000080.
- Half store of 0x1234ABCD at 0x402: we=1, be=1100, wdata=0xABCDABCD, addr=0x400.
- Word load at 0x101: no req, no stall; next cycle mem_misalign_out=1, wb_we_reg_file_out=0.
- Assert rst_n=0 while in WAIT: req and stall drop immediately. After release, the FSM is in IDLE and wb_valid_out=0.
- Non-memory op with alu 0x55, mux=1, we=1, rd=7, then a load back-to-back: first op is in WB the next cycle with no request; the load's req rises in the following cycle.
